// File: rtl/ms_timeout_timer.sv
// Millisecond timeout timer: counts ms_clk rising edges after a start pulse
// and emits a one-cycle timeout pulse when the programmed limit is reached.
module ms_timeout_timer #(
   parameter int CNT_W = 8
) (
   input  logic             sb_clk,
   input  logic             rst,
   input  logic             ms_clk,
   input  logic             start,
   input  logic             stop,
   input  logic [CNT_W-1:0] timeout_ms,
   output logic             busy,
   output logic             timeout,
   output logic [CNT_W-1:0] elapsed_ms,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      EXPIRE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic             ms_d;
   logic             ms_valid;
   logic             ms_tick;
   logic             start_acc;
   logic [CNT_W-1:0] limit, limit_nxt;
   logic [CNT_W-1:0] elapsed_nxt;

   // ms_valid masks the first sample after reset release, so a level that is
   // already high at release is not mistaken for a rising edge.
   assign ms_tick   = ms_clk & ~ms_d & ms_valid;
   // Stop always wins over a coincident start, in every state.
   assign start_acc = start & ~stop;
   assign state_dbg = state;

   always_comb begin
      state_nxt   = state;
      limit_nxt   = limit;
      elapsed_nxt = elapsed_ms;
      case (state)
         IDLE, EXPIRE: begin
            state_nxt = IDLE;
            if (start_acc) begin
               limit_nxt   = timeout_ms;
               elapsed_nxt = '0;
               state_nxt   = (timeout_ms != '0) ? RUN : EXPIRE;
            end
         end
         RUN: begin
            if (stop) begin
               state_nxt = IDLE;
            end else if (start) begin
               limit_nxt   = timeout_ms;
               elapsed_nxt = '0;
               state_nxt   = (timeout_ms != '0) ? RUN : EXPIRE;
            end else if (ms_tick) begin
               elapsed_nxt = elapsed_ms + CNT_W'(1);
               if (elapsed_ms == limit - CNT_W'(1)) begin
                  state_nxt = EXPIRE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge sb_clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         ms_d       <= 1'b0;
         ms_valid   <= 1'b0;
         limit      <= '0;
         elapsed_ms <= '0;
         busy       <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state      <= state_nxt;
         ms_d       <= ms_clk;
         ms_valid   <= 1'b1;
         limit      <= limit_nxt;
         elapsed_ms <= elapsed_nxt;
         busy       <= (state_nxt == RUN);
         timeout    <= (state_nxt == EXPIRE);
      end
   end

endmodule

// File: tb/tb_ms_timeout_timer.sv
// Directed bench for ms_timeout_timer: expected output-change tuples are queued
// by the stimulus and consumed by a monitor whenever the outputs change.
module tb_ms_timeout_timer;

   localparam int CNT_W = 8;
   localparam int TW    = CNT_W + 2;

   logic             sb_clk = 1'b0;
   logic             rst    = 1'b0;
   logic             ms_clk = 1'b0;
   logic             start  = 1'b0;
   logic             stop   = 1'b0;
   logic [CNT_W-1:0] timeout_ms = '0;
   logic             busy;
   logic             timeout;
   logic [CNT_W-1:0] elapsed_ms;
   logic [1:0]       state_dbg;

   // Tuple layout: {busy, timeout, elapsed_ms}
   logic [TW-1:0] exp_q[$];
   logic [TW-1:0] prev_t;
   logic [TW-1:0] cur_t;
   logic          mon_en = 1'b0;
   int            n_vec  = 0;
   int            n_err  = 0;

   ms_timeout_timer #(.CNT_W(CNT_W)) dut (
      .sb_clk     (sb_clk),
      .rst        (rst),
      .ms_clk     (ms_clk),
      .start      (start),
      .stop       (stop),
      .timeout_ms (timeout_ms),
      .busy       (busy),
      .timeout    (timeout),
      .elapsed_ms (elapsed_ms),
      .state_dbg  (state_dbg)
   );

   // clock / reset
   always #5 sb_clk = ~sb_clk;

   // monitor: every change of the output tuple consumes one expected entry
   always @(posedge sb_clk) begin
      #1;
      if (mon_en) begin
         cur_t = {busy, timeout, elapsed_ms};
         if (cur_t !== prev_t) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_change: got busy=%0b timeout=%0b elapsed=%0d, required no change from %h",
                        busy, timeout, elapsed_ms, prev_t);
            end else begin
               logic [TW-1:0] e;
               e = exp_q.pop_front();
               if (cur_t !== e) begin
                  n_err++;
                  $display("FAIL tuple @%0t: got busy=%0b timeout=%0b elapsed=%0d, required busy=%0b timeout=%0b elapsed=%0d",
                           $time, cur_t[TW-1], cur_t[TW-2], cur_t[CNT_W-1:0], e[TW-1], e[TW-2], e[CNT_W-1:0]);
               end
            end
            prev_t = cur_t;
         end
      end
   end

   function automatic logic [TW-1:0] tup(input logic b, input logic t, input int el);
      return {b, t, CNT_W'(el)};
   endfunction

   task automatic push(input logic b, input logic t, input int el);
      exp_q.push_back(tup(b, t, el));
   endtask

   task automatic check(input string name, input int act, input int req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // driver tasks (inputs change on the falling edge)
   task automatic wait_cyc(input int n);
      repeat (n) @(negedge sb_clk);
   endtask

   task automatic ms_pulse();
      @(negedge sb_clk);
      ms_clk = 1'b1;
      wait_cyc(3);
      ms_clk = 1'b0;
      wait_cyc(3);
   endtask

   task automatic start_cmd(input int val, input logic stp, input logic with_ms);
      @(negedge sb_clk);
      start      = 1'b1;
      stop       = stp;
      timeout_ms = CNT_W'(val);
      if (with_ms) ms_clk = 1'b1;
      @(negedge sb_clk);
      start = 1'b0;
      stop  = 1'b0;
      if (with_ms) begin
         wait_cyc(3);
         ms_clk = 1'b0;
         wait_cyc(3);
      end
   endtask

   task automatic stop_cmd();
      @(negedge sb_clk);
      stop = 1'b1;
      @(negedge sb_clk);
      stop = 1'b0;
   endtask

   task automatic drain(input string name);
      wait_cyc(4);
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      // reset state
      #23;
      check("reset_busy", busy, 0);
      check("reset_timeout", timeout, 0);
      check("reset_elapsed", elapsed_ms, 0);
      check("reset_state", state_dbg, 0);
      @(negedge sb_clk);
      rst = 1'b1;
      prev_t = '0;
      mon_en = 1'b1;
      wait_cyc(2);

      // start 3: counts 1,2,3 then one-cycle timeout, elapsed held
      push(1, 0, 0); push(1, 0, 1); push(1, 0, 2); push(0, 1, 3); push(0, 0, 3);
      start_cmd(3, 1'b0, 1'b0);
      check("s1_busy_after_start", busy, 1);
      ms_pulse(); ms_pulse(); ms_pulse();
      wait_cyc(3);
      check("s1_elapsed_held", elapsed_ms, 3);
      drain("s1_queue_empty");

      // start 5, stop after 2 edges, no timeout over 10 ms
      push(1, 0, 0); push(1, 0, 1); push(1, 0, 2); push(0, 0, 2);
      start_cmd(5, 1'b0, 1'b0);
      ms_pulse(); ms_pulse();
      stop_cmd();
      repeat (10) ms_pulse();
      check("s2_elapsed_held", elapsed_ms, 2);
      drain("s2_queue_empty");

      // start 0: immediate expiry, busy never high
      push(0, 1, 0); push(0, 0, 0);
      start_cmd(0, 1'b0, 1'b0);
      check("s3_timeout_pulse", timeout, 1);
      drain("s3_queue_empty");

      // start 4, restart with 2 at elapsed 3, no expiry at the original 4
      push(1, 0, 0); push(1, 0, 1); push(1, 0, 2); push(1, 0, 3);
      push(1, 0, 0); push(1, 0, 1); push(0, 1, 2); push(0, 0, 2);
      start_cmd(4, 1'b0, 1'b0);
      ms_pulse(); ms_pulse(); ms_pulse();
      start_cmd(2, 1'b0, 1'b0);
      ms_pulse(); ms_pulse();
      repeat (3) ms_pulse();
      drain("s4_queue_empty");

      // start coincident with a tick: tick not counted
      push(1, 0, 0); push(0, 0, 0);
      start_cmd(3, 1'b0, 1'b1);
      check("s5_tick_not_counted", elapsed_ms, 0);
      stop_cmd();
      // start+stop in IDLE with a tick: stays IDLE
      start_cmd(3, 1'b1, 1'b1);
      check("s5_idle_start_stop_state", state_dbg, 0);
      // start+stop in RUN with a tick: stop wins, elapsed held
      push(1, 0, 0); push(1, 0, 1); push(0, 0, 1);
      start_cmd(5, 1'b0, 1'b0);
      ms_pulse();
      start_cmd(5, 1'b1, 1'b1);
      check("s5_run_start_stop_state", state_dbg, 0);
      check("s5_run_start_stop_elapsed", elapsed_ms, 1);
      drain("s5_queue_empty");

      // asynchronous reset mid-RUN
      push(1, 0, 0); push(1, 0, 1); push(0, 0, 0);
      start_cmd(4, 1'b0, 1'b0);
      ms_pulse();
      @(negedge sb_clk);
      #2 rst = 1'b0;
      #1;
      check("s6_async_busy", busy, 0);
      check("s6_async_timeout", timeout, 0);
      check("s6_async_elapsed", elapsed_ms, 0);
      wait_cyc(2);
      rst = 1'b1;
      repeat (5) ms_pulse();
      check("s6_state_idle", state_dbg, 0);
      drain("s6_queue_empty");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ms_timeout_timer.md
MS_TIMEOUT_TIMER -- requirements
Module: ms_timeout_timer

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the millisecond limit and elapsed counter.
REQ-002 SHALL have input sb_clk, 1 bit: sideband clock; all logic is on its rising edge.
REQ-003 SHALL have input rst, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have input ms_clk, 1 bit: millisecond clock from the sideband clock divider, already sb_clk-registered; one rising edge every 1000 sb_clk cycles.
REQ-005 SHALL have input start, 1 bit: one-cycle pulse that arms or re-arms the timer.
REQ-006 SHALL have input stop, 1 bit: one-cycle pulse that cancels a running timer.
REQ-007 SHALL have input timeout_ms, CNT_W bits: timeout length in ms, sampled only in a cycle with an accepted start.
REQ-008 SHALL have output busy, 1 bit: high while in state RUN.
REQ-009 SHALL have output timeout, 1 bit: registered one-cycle expiry pulse.
REQ-010 SHALL have output elapsed_ms, CNT_W bits: ms edges counted since the last accepted start.

Function
REQ-011 SHALL register ms_clk into ms_d every cycle; ms_tick = ms_clk AND NOT ms_d, i.e. one sb_clk cycle per ms_clk rising edge.
REQ-012 SHALL implement states IDLE, RUN and EXPIRE, encoded in a state register.
REQ-013 In IDLE or EXPIRE, start with timeout_ms != 0 SHALL, on the next edge, enter RUN, latch timeout_ms into limit and clear elapsed_ms to 0.
REQ-014 In IDLE or EXPIRE, start with timeout_ms == 0 SHALL, on the next edge, enter EXPIRE, clear elapsed_ms to 0 and drive timeout = 1.
REQ-015 In RUN, an ms_tick without start or stop SHALL increment elapsed_ms by 1 on that edge.
REQ-016 In RUN, when an ms_tick occurs with elapsed_ms == limit-1, the next edge SHALL set elapsed_ms = limit, enter EXPIRE and drive timeout = 1.
REQ-017 EXPIRE SHALL last exactly one cycle, then return to IDLE unless a start is accepted in that cycle (REQ-013/014); timeout SHALL be 1 only in EXPIRE.
REQ-018 In RUN, stop SHALL return to IDLE on the next edge with no timeout pulse, and elapsed_ms SHALL hold its value.
REQ-019 In RUN, start without stop SHALL restart the timer: relatch limit and clear elapsed_ms to 0. If timeout_ms == 0, it SHALL instead enter EXPIRE.
REQ-020 When start and stop are asserted in the same cycle, stop SHALL win, and this SHALL hold in every state.
REQ-021 An ms_tick in the same cycle as an accepted start SHALL NOT be counted; the first counted tick is the next ms_clk rising edge.
REQ-022 Timing granularity: the expiry delay after start SHALL lie in the range (limit-1, limit] ms, plus 1 sb_clk cycle.
REQ-023 stop in IDLE or EXPIRE SHALL have no effect, apart from suppressing a same-cycle start.
REQ-024 In IDLE, elapsed_ms SHALL hold its last value; it SHALL never exceed limit and SHALL never wrap.

Reset
REQ-025 While rst = 0, the block SHALL asynchronously force the following, independent of sb_clk: state = IDLE, ms_d = 0, limit = 0, elapsed_ms = 0, busy = 0, timeout = 0.
REQ-026 Reset mid-RUN SHALL abandon the count with no timeout pulse; after release the block SHALL wait in IDLE for a new start.
REQ-027 After rst release, the first ms_tick SHALL occur only on the first 0->1 transition of ms_clk observed after release.

Verification
REQ-028 Bench SHALL cover: start with timeout_ms = 3 -> busy = 1 the next cycle; elapsed_ms steps 1, 2, 3 on successive ms_clk rising edges; timeout = 1 for exactly 1 cycle right after the 3rd edge; then busy = 0 and elapsed_ms = 3 held.
REQ-029 Bench SHALL cover: start with 5, stop after the 2nd ms edge -> busy = 0, elapsed_ms = 2 held, and timeout never asserts over the following 10 ms.
REQ-030 Bench SHALL cover: start with timeout_ms = 0 -> timeout = 1 in the cycle after start; busy never asserts; elapsed_ms = 0.
REQ-031 Bench SHALL cover: start with 4, then start with 2 after elapsed_ms = 3 -> elapsed_ms = 0; timeout after the 2nd subsequent edge with elapsed_ms = 2, and no expiry at the original 4.
REQ-032 Bench SHALL cover: start coincident with an ms_tick, and start+stop coincident -> the tick is not counted (elapsed_ms = 0); start+stop leaves the state IDLE.
REQ-033 Bench SHALL cover: rst = 0 asserted mid-RUN between sb_clk edges -> all outputs are 0 immediately; no timeout follows release until a new start.
